// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial D = A - B - Bin, LSB first, start/busy/done.
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             inBin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] outD,
    output logic             outB,
    output logic             outZ
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;

    logic             w_a;
    logic             w_b;
    logic             w_diff;
    logic             borrow_d;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        w_a      = a_sh_q[0];
        w_b      = b_sh_q[0];
        w_diff   = w_a ^ w_b ^ borrow_q;
        borrow_d = (~w_a & w_b) | (~(w_a ^ w_b) & borrow_q);
        res_d    = {w_diff, res_q[WIDTH-1:1]};
    end

    // The public result registers load only on the final SHIFT edge, so partial
    // sums never reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            outD     <= '0;
            outB     <= 1'b0;
            outZ     <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_sh_q   <= inA;
                        b_sh_q   <= inB;
                        borrow_q <= inBin;
                        res_q    <= '0;
                        cnt_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == c_last) begin
                        outD    <= res_d;
                        outB    <= borrow_d;
                        outZ    <= (res_d == '0);
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : table vectors + scoreboard for serial_subtractor.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       z;
    } vec8_t;

    typedef struct {
        logic [3:0] d;
        logic       bo;
        logic       z;
    } exp4_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] inA8 = '0;
    logic [7:0] inB8 = '0;
    logic       inBin8 = 1'b0;
    logic       busy8, done8, outB8, outZ8;
    logic [7:0] outD8;

    logic       start4 = 1'b0;
    logic [3:0] inA4 = '0;
    logic [3:0] inB4 = '0;
    logic       inBin4 = 1'b0;
    logic       busy4, done4, outB4, outZ4;
    logic [3:0] outD4;

    int checks = 0;
    int errors = 0;
    int done8_cnt = 0;
    int done4_cnt = 0;

    vec8_t q8[$];
    exp4_t q4[$];
    vec8_t tbl[8];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .inA(inA8), .inB(inB8),
        .inBin(inBin8), .busy(busy8), .done(done8), .outD(outD8),
        .outB(outB8), .outZ(outZ8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .inA(inA4), .inB(inB4),
        .inBin(inBin4), .busy(busy4), .done(done4), .outD(outD4),
        .outB(outB4), .outZ(outZ4)
    );

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Scoreboard side: every done pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (rst_n && done8) begin
            done8_cnt++;
            if (q8.size() == 0) begin
                check("sb8_spurious_done", 1, 0);
            end else begin
                vec8_t e;
                e = q8.pop_front();
                check("sb8_outD", int'(outD8), int'(e.d));
                check("sb8_outB", int'(outB8), int'(e.bo));
                check("sb8_outZ", int'(outZ8), int'(e.z));
                check("sb8_busy_in_done", int'(busy8), 1);
            end
        end
        if (rst_n && done4) begin
            done4_cnt++;
            if (q4.size() == 0) begin
                check("sb4_spurious_done", 1, 0);
            end else begin
                exp4_t e;
                e = q4.pop_front();
                check("sb4_outD", int'(outD4), int'(e.d));
                check("sb4_outB", int'(outB4), int'(e.bo));
                check("sb4_outZ", int'(outZ4), int'(e.z));
            end
        end
    end

    task automatic run_op8(input vec8_t v);
        logic [7:0] prev;
        int n;
        q8.push_back(v);
        prev = outD8;
        @(negedge clk);
        start8 = 1'b1; inA8 = v.a; inB8 = v.b; inBin8 = v.bin;
        @(negedge clk);
        start8 = 1'b0;
        inA8 = 8'($urandom); inB8 = 8'($urandom); inBin8 = 1'($urandom);
        n = 1;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 4) check("op8_outD_hold_mid_shift", int'(outD8), int'(prev));
        end
        check("op8_latency", n, 9);
        @(negedge clk);
        check("op8_done_single_pulse", int'(done8), 0);
        check("op8_busy_after_done", int'(busy8), 0);
    endtask

    task automatic run_op4(input int a, input int b, input int bin);
        int diff;
        int n;
        exp4_t e;
        diff = a - b - bin;
        e.d  = diff[3:0];
        e.bo = (a < b + bin);
        e.z  = (diff[3:0] == 4'd0);
        q4.push_back(e);
        @(negedge clk);
        start4 = 1'b1; inA4 = 4'(a); inB4 = 4'(b); inBin4 = 1'(bin);
        @(negedge clk);
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("op4_latency", n, 5);
        @(negedge clk);
    endtask

    initial begin
        int base;
        vec8_t v;

        tbl[0] = '{8'd5,    8'd3,    1'b0, 8'd2,    1'b0, 1'b0};
        tbl[1] = '{8'd3,    8'd5,    1'b0, 8'hFE,   1'b1, 1'b0};
        tbl[2] = '{8'h80,   8'h7F,   1'b1, 8'h00,   1'b0, 1'b1};
        tbl[3] = '{8'h00,   8'h00,   1'b1, 8'hFF,   1'b1, 1'b0};
        tbl[4] = '{8'hFF,   8'h00,   1'b0, 8'hFF,   1'b0, 1'b0};
        tbl[5] = '{8'h00,   8'hFF,   1'b0, 8'h01,   1'b1, 1'b0};
        tbl[6] = '{8'hFF,   8'hFF,   1'b1, 8'hFF,   1'b1, 1'b0};
        tbl[7] = '{8'd100,  8'd100,  1'b0, 8'h00,   1'b0, 1'b1};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy8), 0);
        check("rst_done", int'(done8), 0);
        check("rst_outD", int'(outD8), 0);
        check("rst_outB", int'(outB8), 0);
        check("rst_outZ", int'(outZ8), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", int'(busy8), 0);

        for (int i = 0; i < 8; i++) run_op8(tbl[i]);

        // start pulses while busy are ignored
        base = done8_cnt;
        v = '{8'd10, 8'd4, 1'b0, 8'd6, 1'b0, 1'b0};
        q8.push_back(v);
        @(negedge clk);
        start8 = 1'b1; inA8 = 8'd10; inB8 = 8'd4; inBin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        for (int n = 2; n <= 24; n++) begin
            @(negedge clk);
            if (n == 3 || n == 9) begin start8 = 1'b1; inA8 = 8'd1; inB8 = 8'd1; end
            else start8 = 1'b0;
        end
        check("busy_ignore_done_count", done8_cnt - base, 1);

        // start held from the DONE cycle into IDLE is accepted
        base = done8_cnt;
        q8.push_back('{8'd7, 8'd2, 1'b0, 8'd5, 1'b0, 1'b0});
        q8.push_back('{8'd9, 8'd1, 1'b0, 8'd8, 1'b0, 1'b0});
        @(negedge clk);
        start8 = 1'b1; inA8 = 8'd7; inB8 = 8'd2; inBin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        for (int n = 1; n < 20 && !done8; n++) @(negedge clk);
        start8 = 1'b1; inA8 = 8'd9; inB8 = 8'd1;
        repeat (2) @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        check("held_start_done_count", done8_cnt - base, 2);
        check("held_start_outD", int'(outD8), 8);

        // reset in the middle of SHIFT
        base = done8_cnt;
        @(negedge clk);
        start8 = 1'b1; inA8 = 8'd50; inB8 = 8'd20; inBin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("midop_busy_before_rst", int'(busy8), 1);
        rst_n = 1'b0;
        #1;
        check("midop_rst_busy", int'(busy8), 0);
        check("midop_rst_outD", int'(outD8), 0);
        check("midop_rst_outZ", int'(outZ8), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midop_no_done", done8_cnt - base, 0);
        run_op8('{8'd200, 8'd55, 1'b0, 8'd145, 1'b0, 1'b0});

        // exhaustive 4-bit sweep
        base = done4_cnt;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bin = 0; bin < 2; bin++)
                    run_op4(a, b, bin);
        repeat (3) @(negedge clk);
        check("sweep4_done_count", done4_cnt - base, 512);
        check("sb4_queue_empty", q4.size(), 0);
        check("sb8_queue_empty", q8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
